// File: rtl/pid_core.sv
// pid_core: 8-bit PID controller, one sample per 6 cycles, one shared multiplier.
// Ports: clk, reset (sync, active-high), params/params_ok (SPI parameter word),
//   pv/pv_valid (process sample in), out/out_valid (actuator command), busy.
module pid_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] params,
  input  logic        params_ok,
  input  logic [7:0]  pv,
  input  logic        pv_valid,
  output logic [7:0]  out,
  output logic        out_valid,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERR,
    S_P,
    S_I,
    S_D,
    S_OUT
  } state_t;

  localparam logic [31:0] SHADOW_RST = 32'h4A23_0010;

  state_t             state_q;
  logic [31:0]        shadow_q;
  logic [7:0]         pv_q;
  logic signed [8:0]  e_q;
  logic signed [8:0]  eprev_q;
  logic signed [9:0]  dlt_q;
  logic signed [15:0] integ_q;
  logic signed [23:0] acc_q;
  logic [7:0]         out_q;
  logic               out_valid_q;
  logic               busy_q;

  logic [7:0] sp;
  logic [3:0] kp, ki, kd, shift;
  logic [7:0] bias;

  assign sp    = shadow_q[31:24];
  assign kp    = shadow_q[23:20];
  assign ki    = shadow_q[19:16];
  assign kd    = shadow_q[15:12];
  assign shift = shadow_q[11:8];
  assign bias  = shadow_q[7:0];

  // Error path, evaluated in ERR
  logic signed [8:0]  e_d;
  logic signed [9:0]  dlt_d;
  logic signed [16:0] isum;
  logic signed [15:0] integ_d;

  assign e_d   = $signed({1'b0, sp}) - $signed({1'b0, pv_q});
  assign dlt_d = $signed({e_d[8], e_d}) - $signed({eprev_q[8], eprev_q});
  assign isum  = $signed({integ_q[15], integ_q})
               + $signed({{8{e_d[8]}}, e_d});

  // Saturate: overflow when the two top bits of the 17-bit sum disagree
  always_comb begin
    integ_d = isum[15:0];
    if (isum[16] != isum[15]) begin
      integ_d = isum[16] ? 16'sh8000 : 16'sh7FFF;
    end
  end

  // Shared multiplier: unsigned 4-bit coefficient x signed 16-bit operand
  logic [3:0]         mul_k;
  logic signed [15:0] mul_op;
  logic signed [20:0] prod;
  logic signed [23:0] prod_x;

  always_comb begin
    mul_k  = 4'd0;
    mul_op = 16'sd0;
    unique case (state_q)
      S_P: begin
        mul_k  = kp;
        mul_op = {{7{e_q[8]}}, e_q};
      end
      S_I: begin
        mul_k  = ki;
        mul_op = integ_q;
      end
      S_D: begin
        mul_k  = kd;
        mul_op = {{6{dlt_q[9]}}, dlt_q};
      end
      default: begin
        mul_k  = 4'd0;
        mul_op = 16'sd0;
      end
    endcase
  end

  assign prod   = $signed({17'd0, mul_k}) * $signed({{5{mul_op[15]}}, mul_op});
  assign prod_x = {{3{prod[20]}}, prod};

  // Output stage: floor shift, add bias, clamp to 0..255
  logic signed [23:0] acc_sh;
  logic signed [24:0] u;
  logic [7:0]         u_clamp;

  assign acc_sh = acc_q >>> shift;
  assign u      = $signed({acc_sh[23], acc_sh}) + $signed({17'd0, bias});

  always_comb begin
    u_clamp = u[7:0];
    if (u[24]) begin
      u_clamp = 8'd0;
    end else if (|u[23:8]) begin
      u_clamp = 8'd255;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shadow_q    <= SHADOW_RST;
      pv_q        <= 8'd0;
      e_q         <= 9'sd0;
      eprev_q     <= 9'sd0;
      dlt_q       <= 10'sd0;
      integ_q     <= 16'sd0;
      acc_q       <= 24'sd0;
      out_q       <= 8'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pv_valid) begin
            pv_q    <= pv;
            busy_q  <= 1'b1;
            state_q <= S_ERR;
            if (params_ok) begin
              shadow_q <= params;
            end
          end
        end
        S_ERR: begin
          e_q     <= e_d;
          dlt_q   <= dlt_d;
          integ_q <= integ_d;
          state_q <= S_P;
        end
        S_P: begin
          acc_q   <= prod_x;
          state_q <= S_I;
        end
        S_I: begin
          acc_q   <= acc_q + prod_x;
          state_q <= S_D;
        end
        S_D: begin
          acc_q   <= acc_q + prod_x;
          state_q <= S_OUT;
        end
        S_OUT: begin
          out_q       <= u_clamp;
          out_valid_q <= 1'b1;
          eprev_q     <= e_q;
          busy_q      <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pid_core.sv
// tb_pid_core: randomized + directed bench for pid_core against an
// arithmetic reference model of the PID update.
module tb_pid_core;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] params;
  logic        params_ok;
  logic [7:0]  pv;
  logic        pv_valid;
  logic [7:0]  out;
  logic        out_valid;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  pid_core dut (
    .clk       (clk),
    .reset     (reset),
    .params    (params),
    .params_ok (params_ok),
    .pv        (pv),
    .pv_valid  (pv_valid),
    .out       (out),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_shadow;
  int          m_integ;
  int          m_eprev;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic m_reset();
    m_shadow = 32'h4A23_0010;
    m_integ  = 0;
    m_eprev  = 0;
  endtask

  function automatic int model_step(input int pvv);
    int sp, kp, ki, kd, sh, bias, e, d, acc, u;
    sp   = int'(m_shadow[31:24]);
    kp   = int'(m_shadow[23:20]);
    ki   = int'(m_shadow[19:16]);
    kd   = int'(m_shadow[15:12]);
    sh   = int'(m_shadow[11:8]);
    bias = int'(m_shadow[7:0]);
    e = sp - pvv;
    d = e - m_eprev;
    m_integ = m_integ + e;
    if (m_integ > 32767) m_integ = 32767;
    if (m_integ < -32768) m_integ = -32768;
    acc = kp * e + ki * m_integ + kd * d;
    u = (acc >>> sh) + bias;
    if (u < 0) u = 0;
    if (u > 255) u = 255;
    m_eprev = e;
    return u;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    pv_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out", int'(out), 0);
    chk("rst_ov", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
  endtask

  task automatic run_sample(input logic [7:0] p, input logic [31:0] prm,
                            input logic ok, input bit spam,
                            output int got);
    int exp, first, nv, bz;
    first = 0;
    nv    = 0;
    bz    = 1;
    got   = -1;
    @(negedge clk);
    pv        = p;
    params    = prm;
    params_ok = ok;
    pv_valid  = 1'b1;
    if (ok) m_shadow = prm;
    exp = model_step(int'(p));
    @(posedge clk);
    #1;
    chk("busy_e0", int'(busy), 1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      pv_valid  = spam && (k <= 5);
      pv        = 8'($urandom);
      params    = $urandom;
      params_ok = 1'($urandom);
      @(posedge clk);
      #1;
      if (out_valid) begin
        nv++;
        if (first == 0) begin
          first = k;
          got   = int'(out);
        end
      end
      if (int'(k < 5) != int'(busy)) bz = 0;
    end
    @(negedge clk);
    pv_valid = 1'b0;
    chk("latency", first, 5);
    chk("n_valid", nv, 1);
    chk("busy_pat", bz, 1);
    chk("out", got, exp);
    chk("hold", int'(out), exp);
  endtask

  initial begin
    int got, nv;
    reset     = 1'b1;
    params    = 32'd0;
    params_ok = 1'b0;
    pv        = 8'd0;
    pv_valid  = 1'b0;
    m_reset();
    do_reset();

    // Default shadow, live params ignored
    run_sample(8'd70, 32'hFFFF_FFFF, 1'b0, 1'b0, got);
    chk("d_first", got, 36);
    run_sample(8'd70, 32'h0000_0000, 1'b0, 1'b1, got);
    chk("d_second", got, 48);

    do_reset();
    run_sample(8'd0, 32'h0, 1'b0, 1'b0, got);
    chk("d_sat_hi", got, 255);
    do_reset();
    run_sample(8'd200, 32'h0, 1'b0, 1'b0, got);
    chk("d_sat_lo", got, 0);

    do_reset();
    run_sample(8'd100, 32'h8010_0000, 1'b1, 1'b0, got);
    chk("d_load", got, 28);
    do_reset();
    run_sample(8'd100, 32'h8010_0000, 1'b0, 1'b0, got);
    chk("d_noload", got, 0);

    // Reset at E3 aborts the computation
    do_reset();
    @(negedge clk);
    pv        = 8'd70;
    params_ok = 1'b0;
    pv_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pv_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    nv = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) nv++;
    end
    chk("abort_ov", nv, 0);
    chk("abort_out", int'(out), 0);
    chk("abort_busy", int'(busy), 0);
    m_reset();
    run_sample(8'd70, 32'h0, 1'b0, 1'b0, got);
    chk("abort_next", got, 36);

    // Randomized samples with periodic resets
    for (int n = 0; n < 60; n++) begin
      if (n % 15 == 14) do_reset();
      run_sample(8'($urandom), $urandom, 1'($urandom), 1'($urandom), got);
    end

    // Integrator windup must pin, never wrap
    do_reset();
    run_sample(8'd0, {8'd255, 4'd0, 4'd15, 4'd0, 4'd15, 8'd0},
               1'b1, 1'b0, got);
    for (int n = 1; n < 200; n++) begin
      run_sample(8'd0, 32'h0, 1'b0, 1'b0, got);
    end
    chk("windup", got, 14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
